// File: rtl/apb_master_port.sv
// APB3 initiator: converts a valid/ready command into single APB transfers,
// with peripheral wait states, slave-error capture and a programmable wait timeout.
module apb_master_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  // Counter holds the full TIMEOUT value; a 1-bit saturating counter when disabled.
  localparam int               CNT_W    = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic             TO_EN    = (TIMEOUT != 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t             state_r,       state_s;
  logic               psel_r,        psel_s;
  logic               penable_r,     penable_s;
  logic               pwrite_r,      pwrite_s;
  logic [ADDR_W-1:0]  paddr_r,       paddr_s;
  logic [DATA_W-1:0]  pwdata_r,      pwdata_s;
  logic               rsp_valid_r,   rsp_valid_s;
  logic [DATA_W-1:0]  rsp_rdata_r,   rsp_rdata_s;
  logic               rsp_err_r,     rsp_err_s;
  logic               rsp_timeout_r, rsp_timeout_s;
  logic [CNT_W-1:0]   wait_cnt_r,    wait_cnt_s;
  logic [CNT_W-1:0]   wait_inc_s;
  logic               accept_s;
  logic               expire_s;

  assign cmd_ready_o = (state_r == ST_IDLE) & ~rst_i;
  assign accept_s    = cmd_valid_i & cmd_ready_o;

  // Saturate so a disabled timeout never wraps back onto the limit.
  assign wait_inc_s  = (wait_cnt_r == {CNT_W{1'b1}}) ? wait_cnt_r : (wait_cnt_r + CNT_W'(1));
  assign expire_s    = TO_EN & (wait_inc_s == TO_LIMIT);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_s       = state_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    pwrite_s      = pwrite_r;
    paddr_s       = paddr_r;
    pwdata_s      = pwdata_r;
    rsp_valid_s   = 1'b0;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    rsp_timeout_s = rsp_timeout_r;
    wait_cnt_s    = wait_cnt_r;

    case (state_r)
      ST_IDLE: begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        if (accept_s) begin
          state_s    = ST_SETUP;
          psel_s     = 1'b1;
          pwrite_s   = cmd_write_i;
          paddr_s    = cmd_addr_i;
          pwdata_s   = cmd_wdata_i;
          wait_cnt_s = {CNT_W{1'b0}};
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s   = ST_ACCESS;
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          state_s       = ST_IDLE;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_rdata_s   = pwrite_r ? {DATA_W{1'b0}} : prdata_i;
          rsp_err_s     = pslverr_i;
          rsp_timeout_s = 1'b0;
        end else if (expire_s) begin
          state_s       = ST_IDLE;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_rdata_s   = {DATA_W{1'b0}};
          rsp_err_s     = 1'b1;
          rsp_timeout_s = 1'b1;
          wait_cnt_s    = wait_inc_s;
        end else begin
          wait_cnt_s    = wait_inc_s;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        psel_s    = 1'b0;
        penable_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_W{1'b0}};
      pwdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      wait_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      pwrite_r      <= pwrite_s;
      paddr_r       <= paddr_s;
      pwdata_r      <= pwdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
      wait_cnt_r    <= wait_cnt_s;
    end
  end

  assign psel_o        = psel_r;
  assign penable_o     = penable_r;
  assign pwrite_o      = pwrite_r;
  assign paddr_o       = paddr_r;
  assign pwdata_o      = pwdata_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_rdata_o   = rsp_rdata_r;
  assign rsp_err_o     = rsp_err_r;
  assign rsp_timeout_o = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_port.sv
// Directed bench for apb_master_port: latency, wait states, slave error,
// timeout abort, back-to-back commands and mid-transfer reset.
module tb_apb_master_port;

  logic        pclk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 pclk_i = ~pclk_i;

  apb_master_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk_i       (pclk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk_i);
    #1;
  endtask

  // ready_at: ACCESS cycle index in which pready_i is high (0 = never).
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ready_at, input logic slverr,
                         output int pen_cycles, output int lat);
    bit got;
    check_eq("ready_before_accept", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    prdata_i    = rdata;
    pslverr_i   = slverr;
    pready_i    = 1'b0;
    tick;
    cmd_valid_i = 1'b0;
    cmd_write_i = ~wr;
    cmd_addr_i  = 32'hDEAD_BEEF;
    cmd_wdata_i = 32'h0BAD_F00D;
    pen_cycles  = 0;
    lat         = 1;
    got         = 1'b0;
    while (!got && lat < 60) begin
      if (lat == 1) begin
        check_eq("setup_psel", 32'(psel_o), 32'd1);
        check_eq("setup_penable", 32'(penable_o), 32'd0);
      end
      if (lat == 2) check_eq("access_penable", 32'(penable_o), 32'd1);
      if (psel_o) begin
        check_eq("paddr_stable", paddr_o, addr);
        check_eq("pwrite_stable", 32'(pwrite_o), 32'(wr));
        if (wr) check_eq("pwdata_stable", pwdata_o, wdata);
      end
      if (penable_o) pen_cycles++;
      pready_i = (ready_at != 0) && (pen_cycles >= ready_at);
      tick;
      lat++;
      got = rsp_valid_o;
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    check_eq("rsp_seen", 32'(got), 32'd1);
    check_eq("psel_after_rsp", 32'(psel_o), 32'd0);
    check_eq("penable_after_rsp", 32'(penable_o), 32'd0);
    check_eq("ready_with_rsp", 32'(cmd_ready_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pen, lat, idx, n_rsp, n_setup;
    int acc_cyc [3];
    logic [31:0] setup_addr [3];
    logic [31:0] exp_addr [3];
    logic acc;

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 32'h0;
    cmd_wdata_i = 32'h0; prdata_i = 32'h0; pready_i = 1'b0; pslverr_i = 1'b0;
    tick; tick;
    check_eq("rst_psel", 32'(psel_o), 32'd0);
    check_eq("rst_penable", 32'(penable_o), 32'd0);
    check_eq("rst_pwrite", 32'(pwrite_o), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
    check_eq("rst_paddr", paddr_o, 32'h0);
    check_eq("rst_pwdata", pwdata_o, 32'h0);
    check_eq("rst_rdata", rsp_rdata_o, 32'h0);
    check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check_eq("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);

    // Zero-wait write; prdata must be ignored.
    do_xfer(1'b1, 32'h9, 32'h3, 32'hFFFF_FFFF, 1, 1'b0, pen, lat);
    check_eq("wr_latency", 32'(lat), 32'd3);
    check_eq("wr_pen_cycles", 32'(pen), 32'd1);
    check_eq("wr_rdata", rsp_rdata_o, 32'h0);
    check_eq("wr_err", 32'(rsp_err_o), 32'd0);
    check_eq("wr_timeout", 32'(rsp_timeout_o), 32'd0);
    tick;
    check_eq("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);

    // Read with three wait states.
    do_xfer(1'b0, 32'h4, 32'h0, 32'hA5A5_0001, 4, 1'b0, pen, lat);
    check_eq("rdw_pen_cycles", 32'(pen), 32'd4);
    check_eq("rdw_latency", 32'(lat), 32'd6);
    check_eq("rdw_rdata", rsp_rdata_o, 32'hA5A5_0001);
    check_eq("rdw_err", 32'(rsp_err_o), 32'd0);
    tick;
    check_eq("rdw_pulse_end", 32'(rsp_valid_o), 32'd0);
    check_eq("rdw_rdata_hold", rsp_rdata_o, 32'hA5A5_0001);

    // Slave error on a read; next commands are issued during the rsp cycle.
    do_xfer(1'b0, 32'h8, 32'h0, 32'h1234_5678, 1, 1'b1, pen, lat);
    check_eq("slverr_err", 32'(rsp_err_o), 32'd1);
    check_eq("slverr_timeout", 32'(rsp_timeout_o), 32'd0);
    check_eq("slverr_rdata", rsp_rdata_o, 32'h1234_5678);
    check_eq("slverr_latency", 32'(lat), 32'd3);

    // Timeout abort after 16 low ACCESS cycles.
    do_xfer(1'b0, 32'h20, 32'h0, 32'h5555_AAAA, 0, 1'b0, pen, lat);
    check_eq("to_pen_cycles", 32'(pen), 32'd16);
    check_eq("to_latency", 32'(lat), 32'd18);
    check_eq("to_err", 32'(rsp_err_o), 32'd1);
    check_eq("to_timeout", 32'(rsp_timeout_o), 32'd1);
    check_eq("to_rdata", rsp_rdata_o, 32'h0);

    do_xfer(1'b1, 32'h24, 32'h77, 32'h0, 1, 1'b0, pen, lat);
    check_eq("post_to_latency", 32'(lat), 32'd3);
    check_eq("post_to_err", 32'(rsp_err_o), 32'd0);
    check_eq("post_to_timeout", 32'(rsp_timeout_o), 32'd0);
    tick;

    // Back-to-back writes with cmd_valid_i held high.
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h30;
    idx = 0; n_rsp = 0; n_setup = 0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = exp_addr[0]; cmd_wdata_i = 32'hA1;
    pready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = cmd_valid_i && cmd_ready_o;
      tick;
      if (rsp_valid_o) n_rsp++;
      if (psel_o && !penable_o && n_setup < 3) begin
        setup_addr[n_setup] = paddr_o;
        n_setup++;
      end
      if (acc && idx < 3) begin
        acc_cyc[idx] = c;
        idx++;
        if (idx < 3) begin
          cmd_addr_i  = exp_addr[idx];
          cmd_wdata_i = 32'hA1 + 32'(idx);
        end else begin
          cmd_valid_i = 1'b0;
        end
      end
    end
    pready_i = 1'b0;
    check_eq("b2b_accepts", 32'(idx), 32'd3);
    check_eq("b2b_rsp_count", 32'(n_rsp), 32'd3);
    check_eq("b2b_setups", 32'(n_setup), 32'd3);
    if (idx == 3) begin
      check_eq("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check_eq("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end
    if (n_setup == 3) begin
      for (int k = 0; k < 3; k++) check_eq("b2b_addr_order", setup_addr[k], exp_addr[k]);
    end

    // Leave a non-zero response behind, then reset in the middle of ACCESS.
    do_xfer(1'b0, 32'h50, 32'h0, 32'hCAFE_0001, 1, 1'b1, pen, lat);
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h44; pready_i = 1'b0;
    tick;
    cmd_valid_i = 1'b0;
    tick;
    check_eq("mid_access_penable", 32'(penable_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_eq("rst_mid_ready", 32'(cmd_ready_o), 32'd0);
    tick;
    check_eq("rst_mid_psel", 32'(psel_o), 32'd0);
    check_eq("rst_mid_penable", 32'(penable_o), 32'd0);
    check_eq("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_mid_rdata", rsp_rdata_o, 32'h0);
    check_eq("rst_mid_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_mid_ready2", 32'(cmd_ready_o), 32'd0);
    pready_i = 1'b1;
    tick;
    check_eq("rst_hold_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(cmd_ready_o), 32'd1);
    tick;
    check_eq("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("post_rst_psel", 32'(psel_o), 32'd0);
    pready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
Name: apb_master_port

Overview:
- APB initiator that turns a simple valid/ready command interface into single APB3 read/write transfers toward peripherals such as the interrupt controller.
- Supports peripheral wait states through pready_i and captures pslverr_i.
- A programmable timeout aborts a transfer if the peripheral never responds.
- Sits between the system sequencer / interrupt service logic and the peripheral APB bus.

Parameters:
- ADDR_W, 32, width of command address and paddr_o.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles with pready_i low before abort; 0 disables the timeout.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_W  transfer address.
- cmd_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  slave error or timeout, valid with rsp_valid_o.
- rsp_timeout_o  out  1  timeout abort, valid with rsp_valid_o.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset values: psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; paddr_o, pwdata_o, rsp_rdata_o = 0; state IDLE; timeout counter 0.
- Reset is synchronous and active-high, and applies mid-transfer: psel/penable clear at the next edge and no response is issued.
- FSM states: IDLE, SETUP, ACCESS. All APB and rsp outputs are registered.
- cmd_ready_o = (state == IDLE) & ~rst_i. It is combinational from state only and has no dependency on cmd_valid_i.
- IDLE:
  - When cmd_valid_i & cmd_ready_o at an edge, latch write/addr/wdata into pwrite_o/paddr_o/pwdata_o and go to SETUP.
  - Otherwise stay in IDLE. paddr_o, pwdata_o and pwrite_o hold their last values; psel_o = 0.
- SETUP (exactly one cycle): psel_o = 1, penable_o = 0. Next state is ACCESS.
- ACCESS: psel_o = 1, penable_o = 1. paddr/pwrite/pwdata stay stable throughout.
  - pready_i = 1 sampled:
    - Go to IDLE and pulse rsp_valid_o for the following cycle.
    - rsp_rdata_o = prdata_i for reads, 0 for writes.
    - rsp_err_o = pslverr_i; rsp_timeout_o = 0.
    - psel_o and penable_o drop to 0.
  - pready_i = 0: increment the wait counter.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT (TIMEOUT consecutive low cycles), abort: go to IDLE, deassert psel/penable, pulse rsp_valid_o with rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - The counter clears on entry to SETUP.
  - The counter is wide enough for TIMEOUT and must not wrap when TIMEOUT = 0.
- pslverr_i is ignored unless pready_i = 1 in ACCESS. prdata_i is ignored for writes.
- Latency with zero wait states:
  - Accept edge E0; SETUP in cycle 1; ACCESS in cycle 2.
  - rsp_valid_o is high in cycle 3, and cmd_ready_o is high in cycle 3.
  - Back-to-back throughput is one transfer per 3 cycles.
  - A command presented while rsp_valid_o is high is accepted in that same cycle.
- rsp_valid_o is high for exactly one cycle per accepted command. rsp_err/rsp_timeout/rsp_rdata hold their values until the next response.
- Command inputs are sampled only at acceptance; later changes do not affect the transfer in flight.

Test Plan:
- Reset, then write cmd addr 0x9, data 0x3, pready_i tied 1:
  - psel rises the cycle after acceptance, penable the cycle after that.
  - rsp_valid pulses 3 cycles after acceptance with err = 0, rdata = 0.
  - paddr = 0x9 and pwrite = 1 are stable across SETUP/ACCESS.
- Read addr 0x4, pready_i low 3 ACCESS cycles then high with prdata_i = 0xA5A5_0001: penable held 4 cycles; rsp_rdata = 0xA5A5_0001, err = 0.
- Read with pready_i = 1, pslverr_i = 1: rsp_err = 1, rsp_timeout = 0, FSM back to IDLE.
- TIMEOUT = 16, pready_i held 0:
  - Abort after 16 ACCESS cycles; rsp_err = 1, rsp_timeout = 1, rdata = 0; psel drops.
  - A new command is accepted next.
- cmd_valid_i held high with 3 distinct writes: three transfers, accept-to-accept spacing of 3 cycles, addresses issued in order, 3 rsp pulses.
- rst_i asserted during ACCESS: psel/penable = 0 and cmd_ready = 0 while in reset; no rsp_valid; cmd_ready = 1 the first cycle after reset drops.
